// File: rtl/sgmii_rx_decode.sv
// SGMII / 1000BASE-X receive ordered-set decoder.
// Tracks sync, extracts partner autoneg progress (start/ack/idle) from /C/ and
// /I/ ordered sets, and unwraps /S/../T/ framed packets onto GMII receive.
module sgmii_rx_decode #(
  parameter int unsigned MATCH_COUNT  = 3,
  parameter int unsigned IDLE_COUNT   = 3,
  parameter int unsigned SYNC_ERR_MAX = 4
) (
  input  logic        clk_125mhz,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_is_k,
  input  logic        rx_err,
  output logic        sync_ok,
  output logic        sgmii_autoneg_start,
  output logic        sgmii_autoneg_ack,
  output logic        sgmii_autoneg_idle,
  output logic [15:0] rx_cfg_reg,
  output logic [7:0]  gmii_rxd,
  output logic        gmii_rx_dv,
  output logic        gmii_rx_err
);

  typedef enum logic [2:0] {
    ST_SEEK,
    ST_K_SEEN,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_PKT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cfg_lo_q, cfg_lo_d;
  logic [15:0] prev_cfg_q, prev_cfg_d;
  logic        set_err_q, set_err_d;
  logic [2:0]  err_cnt_q, err_cnt_d;
  logic [1:0]  vs_cnt_q, vs_cnt_d;
  logic [2:0]  match_cnt_q, match_cnt_d;
  logic [2:0]  idle_cnt_q, idle_cnt_d;
  logic        sync_q, sync_d;
  logic        start_q, start_d;
  logic        ack_q, ack_d;
  logic        idle_q, idle_d;
  logic [15:0] cfg_q, cfg_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        dv_q, dv_d;
  logic        rxerr_q, rxerr_d;

  logic        bad, cfg_done, idl_done, set_ok, inc, lose;
  logic [15:0] word;

  assign word = {rx_byte, cfg_lo_q};

  // Parser FSM, sync tracking, autoneg evaluation and GMII output next state.
  always_comb begin
    state_d     = state_q;
    cfg_lo_d    = cfg_lo_q;
    prev_cfg_d  = prev_cfg_q;
    set_err_d   = set_err_q;
    err_cnt_d   = err_cnt_q;
    vs_cnt_d    = vs_cnt_q;
    match_cnt_d = match_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    sync_d      = sync_q;
    start_d     = start_q;
    ack_d       = ack_q;
    idle_d      = idle_q;
    cfg_d       = cfg_q;
    rxd_d       = '0;
    dv_d        = 1'b0;
    rxerr_d     = 1'b0;
    bad         = 1'b0;
    cfg_done    = 1'b0;
    idl_done    = 1'b0;

    unique case (state_q)
      ST_SEEK: begin
        if (rx_is_k && rx_byte == 8'hBC) begin
          state_d   = ST_K_SEEN;
          set_err_d = rx_err;
        end else if (rx_is_k && rx_byte == 8'hFB && idle_q) begin
          state_d = ST_PKT;
          dv_d    = 1'b1;
          rxd_d   = 8'h55;
        end else if (!(rx_is_k && rx_byte == 8'hF7)) begin
          // /R/ after /T/ is silently skipped; everything else is a bad byte
          bad = 1'b1;
        end
      end
      ST_K_SEEN: begin
        state_d   = ST_SEEK;
        set_err_d = set_err_q | rx_err;
        if (!rx_is_k && (rx_byte == 8'hB5 || rx_byte == 8'h42)) begin
          state_d = ST_CFG_LO;
        end else if (!rx_is_k && (rx_byte == 8'hC5 || rx_byte == 8'h50)) begin
          idl_done = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      ST_CFG_LO: begin
        cfg_lo_d  = rx_byte;
        set_err_d = set_err_q | rx_err;
        state_d   = ST_CFG_HI;
      end
      ST_CFG_HI: begin
        cfg_done = 1'b1;
        state_d  = ST_SEEK;
      end
      ST_PKT: begin
        if (!rx_is_k) begin
          dv_d    = 1'b1;
          rxd_d   = rx_byte;
          rxerr_d = rx_err;
        end else if (rx_byte == 8'hFE) begin
          dv_d    = 1'b1;
          rxerr_d = 1'b1;
          rxd_d   = 8'hFE;
        end else if (rx_byte == 8'hFD) begin
          state_d = ST_SEEK;
        end else begin
          dv_d    = 1'b1;
          rxerr_d = 1'b1;
          rxd_d   = rx_byte;
          state_d = ST_SEEK;
        end
      end
      default: state_d = ST_SEEK;
    endcase

    set_ok = (cfg_done || idl_done) && !set_err_q && !rx_err;
    inc    = rx_err || bad;

    if (inc) begin
      if (err_cnt_q != 3'b111) err_cnt_d = err_cnt_q + 3'd1;
      vs_cnt_d = '0;
    end else if (set_ok) begin
      err_cnt_d = '0;
      if (vs_cnt_q != 2'd3) vs_cnt_d = vs_cnt_q + 2'd1;
    end

    lose   = 32'(err_cnt_d) >= SYNC_ERR_MAX;
    sync_d = sync_q || (vs_cnt_d == 2'd3);

    if (cfg_done) begin
      idle_cnt_d = '0;
      idle_d     = 1'b0;
    end

    // Matches are counted while sync is being acquired so the set that
    // completes sync acquisition can also complete a config match.
    if (cfg_done && set_ok) begin
      prev_cfg_d = word;
      if (match_cnt_q != 3'd0 && word == prev_cfg_q) begin
        if (match_cnt_q < 3'(MATCH_COUNT)) match_cnt_d = match_cnt_q + 3'd1;
      end else begin
        match_cnt_d = 3'd1;
      end
      if (match_cnt_d == 3'(MATCH_COUNT) && sync_d) begin
        cfg_d   = word;
        start_d = 1'b1;
        ack_d   = word[14];
      end
    end

    if (idl_done && set_ok && ack_q) begin
      if (idle_cnt_q < 3'(IDLE_COUNT)) idle_cnt_d = idle_cnt_q + 3'd1;
      if (idle_cnt_d == 3'(IDLE_COUNT)) idle_d = 1'b1;
    end

    if (lose) begin
      sync_d      = 1'b0;
      start_d     = 1'b0;
      ack_d       = 1'b0;
      idle_d      = 1'b0;
      match_cnt_d = '0;
      idle_cnt_d  = '0;
      vs_cnt_d    = '0;
      dv_d        = 1'b0;
      rxerr_d     = 1'b0;
      rxd_d       = '0;
      if (state_d == ST_PKT) state_d = ST_SEEK;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      state_q     <= ST_SEEK;
      cfg_lo_q    <= '0;
      prev_cfg_q  <= '0;
      set_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      vs_cnt_q    <= '0;
      match_cnt_q <= '0;
      idle_cnt_q  <= '0;
      sync_q      <= 1'b0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      idle_q      <= 1'b0;
      cfg_q       <= '0;
      rxd_q       <= '0;
      dv_q        <= 1'b0;
      rxerr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_lo_q    <= cfg_lo_d;
      prev_cfg_q  <= prev_cfg_d;
      set_err_q   <= set_err_d;
      err_cnt_q   <= err_cnt_d;
      vs_cnt_q    <= vs_cnt_d;
      match_cnt_q <= match_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      sync_q      <= sync_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      idle_q      <= idle_d;
      cfg_q       <= cfg_d;
      rxd_q       <= rxd_d;
      dv_q        <= dv_d;
      rxerr_q     <= rxerr_d;
    end
  end

  assign sync_ok             = sync_q;
  assign sgmii_autoneg_start = start_q;
  assign sgmii_autoneg_ack   = ack_q;
  assign sgmii_autoneg_idle  = idle_q;
  assign rx_cfg_reg          = cfg_q;
  assign gmii_rxd            = rxd_q;
  assign gmii_rx_dv          = dv_q;
  assign gmii_rx_err         = rxerr_q;

endmodule
